vip_raster_cascade_count: RTL and testbench
===========================================

Name: vip_raster_cascade_count

Overview:
- Parametrised two-level raster position counter (horizontal sample, vertical line) plus frame counter, with a runtime-programmable tick prescaler per sample.
- Successor to the single-axis generic counter. Used by clocked-video input/output timing for active-region position tracking, end-of-line/end-of-frame strobes and position-compare events.
- Colour-plane sequencing comes from the prescaler phase output (cp_ticks).

Parameters:
- H_WIDTH, 12, width of horizontal counter and its max/reset/compare inputs.
- V_WIDTH, 12, width of vertical counter and its max/reset/compare inputs.
- F_WIDTH, 8, width of frame counter.
- TICKS_WIDTH, 2, width of prescaler counter and ticks_m1 input (>=1).
- H_RESET_VALUE, 0, h_count value on reset_n assertion.
- V_RESET_VALUE, 0, v_count value on reset_n assertion.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance qualifier; prescaler/counters move only when high.
- restart  in  1  synchronous reload of all position state; overrides enable.
- ticks_m1  in  TICKS_WIDTH  ticks per sample minus one (0 = one sample per enabled cycle).
- h_max  in  H_WIDTH  last horizontal index (samples per line minus one).
- v_max  in  V_WIDTH  last vertical index (lines per frame minus one).
- h_reload  in  H_WIDTH  h_count value loaded on restart.
- v_reload  in  V_WIDTH  v_count value loaded on restart.
- h_cmp  in  H_WIDTH  horizontal compare position.
- v_cmp  in  V_WIDTH  vertical compare position.
- h_count  out  H_WIDTH  current sample index (registered).
- v_count  out  V_WIDTH  current line index (registered).
- f_count  out  F_WIDTH  frame count (registered, wraps).
- cp_ticks  out  TICKS_WIDTH  current prescaler phase (registered).
- start_sample  out  1  high when ticks==0 (first tick of a sample).
- sample_adv  out  1  enable && ticks>=ticks_m1 (h_count advances this edge).
- eol  out  1  sample_adv && h_count>=h_max (end of line, combinational).
- eof  out  1  eol && v_count>=v_max (end of frame, combinational).
- cmp_hit  out  1  registered one-cycle pulse, see Behaviour.

Behaviour:
- Reset (async, reset_n low): ticks=0, h_count=H_RESET_VALUE, v_count=V_RESET_VALUE, f_count=0, cmp_hit=0. Comb outputs then follow from these values.
- Priority on every edge: restart > enable > hold.
- ticks:
  - restart -> 0.
  - enable && ticks>=ticks_m1 -> 0.
  - enable -> ticks+1.
  - else hold.
- h_count:
  - restart -> h_reload.
  - sample_adv -> (h_count>=h_max ? 0 : h_count+1).
  - else hold.
- v_count:
  - restart -> v_reload.
  - eol -> (v_count>=v_max ? 0 : v_count+1).
  - else hold.
- f_count:
  - restart -> unchanged.
  - eof -> f_count+1, wrapping modulo 2^F_WIDTH.
- Comparisons use >=, never ==, so a max lowered below the current count wraps to 0 on the next advance. No lock-up.
- Runtime max/ticks_m1 changes take effect at the next edge. No shadowing.
- cmp_hit: registered, 1 for exactly one cycle after an edge where sample_adv=1 and the post-edge value of (h_count,v_count) equals (h_cmp,v_cmp).
  - Also pulses after restart when (h_reload,v_reload)==(h_cmp,v_cmp).
  - Otherwise 0.
- Latency:
  - Counts update 1 edge after a qualifying cycle.
  - eol/eof are valid in the same cycle as the qualifying enable.
  - cmp_hit is high in the cycle the matching position is first presented.
- enable low for any length freezes all state and deasserts sample_adv/eol/eof. start_sample still reflects ticks.
- restart together with enable: restart wins, no wrap strobes act. eol/eof may still be asserted combinationally that cycle, but have no effect on state.
- All increments are width-truncated. h_max = 2^H_WIDTH-1 gives the full natural wrap.

Test Plan:
- Reset with H_RESET_VALUE=5 -> h_count=5, v_count=0, f_count=0, cp_ticks=0, cmp_hit=0 during and after reset.
- ticks_m1=0, h_max=3, v_max=1, enable=1 for 8 cycles from 0/0 -> h:0,1,2,3,0,1,2,3; eol in cycles 4 and 8; eof in cycle 8; f_count=1 afterward.
- ticks_m1=2, h_max=1, enable=1 -> cp_ticks 0,1,2 repeating; sample_adv every 3rd cycle; h_count toggles 0/1 each 3 cycles; start_sample on phase 0.
- h_count=9, write h_max=4, one sample_adv -> h_count=0, eol=1 in that cycle. enable toggled 1/0 -> state frozen on 0 cycles.
- restart with enable=1, h_reload=2, v_reload=7 at h=3=h_max -> h=2, v=7, f_count unchanged, ticks=0.
- h_cmp=2, v_cmp=0, run from 0/0 with ticks_m1=0 -> cmp_hit high exactly one cycle, the cycle h_count first reads 2; repeats once per frame.

Source files
------------

// File: rtl/vip_raster_cascade_count.sv
// vip_raster_cascade_count: prescaled horizontal/vertical raster position counter with frame count and position-compare pulse
module vip_raster_cascade_count #(
  parameter int H_WIDTH       = 12,
  parameter int V_WIDTH       = 12,
  parameter int F_WIDTH       = 8,
  parameter int TICKS_WIDTH   = 2,
  parameter int H_RESET_VALUE = 0,
  parameter int V_RESET_VALUE = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [TICKS_WIDTH-1:0] ticks_m1,
  input  logic [H_WIDTH-1:0]     h_max,
  input  logic [V_WIDTH-1:0]     v_max,
  input  logic [H_WIDTH-1:0]     h_reload,
  input  logic [V_WIDTH-1:0]     v_reload,
  input  logic [H_WIDTH-1:0]     h_cmp,
  input  logic [V_WIDTH-1:0]     v_cmp,
  output logic [H_WIDTH-1:0]     h_count,
  output logic [V_WIDTH-1:0]     v_count,
  output logic [F_WIDTH-1:0]     f_count,
  output logic [TICKS_WIDTH-1:0] cp_ticks,
  output logic                   start_sample,
  output logic                   sample_adv,
  output logic                   eol,
  output logic                   eof,
  output logic                   cmp_hit
);
  logic [TICKS_WIDTH-1:0] ticks_next;
  logic [H_WIDTH-1:0]     h_next;
  logic [V_WIDTH-1:0]     v_next;
  logic                   cmp_next;
  // >= rather than == so a max lowered under the live count wraps instead of locking up
  always_comb begin
    start_sample = cp_ticks == '0;
    sample_adv   = enable && cp_ticks >= ticks_m1;
    eol          = sample_adv && h_count >= h_max;
    eof          = eol && v_count >= v_max;
    ticks_next   = (restart || sample_adv) ? '0 : enable ? cp_ticks + 1'b1 : cp_ticks;
    h_next       = restart ? h_reload : !sample_adv ? h_count : h_count >= h_max ? '0 : h_count + 1'b1;
    v_next       = restart ? v_reload : !eol ? v_count : v_count >= v_max ? '0 : v_count + 1'b1;
    cmp_next     = (restart || sample_adv) && h_next == h_cmp && v_next == v_cmp;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cp_ticks <= '0;
      h_count  <= H_WIDTH'(H_RESET_VALUE);
      v_count  <= V_WIDTH'(V_RESET_VALUE);
      f_count  <= '0;
      cmp_hit  <= 1'b0;
    end else begin
      cp_ticks <= ticks_next;
      h_count  <= h_next;
      v_count  <= v_next;
      f_count  <= (!restart && eof) ? f_count + 1'b1 : f_count;
      cmp_hit  <= cmp_next;
    end
endmodule

// File: tb/tb_vip_raster_cascade_count.sv
// tb_vip_raster_cascade_count: directed vectors checked by a queue-based scoreboard monitor
module tb_vip_raster_cascade_count;
  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic [7:0]  f;
    logic [1:0]  t;
    logic [4:0]  flg;
  } obs_t;
  logic        clk = 1'b0;
  logic        reset_n, enable, restart;
  logic [1:0]  ticks_m1;
  logic [11:0] h_max, v_max, h_reload, v_reload, h_cmp, v_cmp;
  logic [11:0] h_count, v_count;
  logic [7:0]  f_count;
  logic [1:0]  cp_ticks;
  logic        start_sample, sample_adv, eol, eof, cmp_hit;
  obs_t        exp_q[$];
  int          id_q[$];
  int          vec_n = 0;
  int          applied = 0;
  int          miscompares = 0;
  always #5 clk = ~clk;
  vip_raster_cascade_count #(.H_RESET_VALUE(5)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .ticks_m1(ticks_m1), .h_max(h_max), .v_max(v_max),
    .h_reload(h_reload), .v_reload(v_reload), .h_cmp(h_cmp), .v_cmp(v_cmp),
    .h_count(h_count), .v_count(v_count), .f_count(f_count), .cp_ticks(cp_ticks),
    .start_sample(start_sample), .sample_adv(sample_adv), .eol(eol), .eof(eof),
    .cmp_hit(cmp_hit)
  );
  // Drives one cycle of inputs and queues the outputs expected during that cycle;
  // flags are {start_sample, sample_adv, eol, eof, cmp_hit}.
  task automatic step(input logic en, input logic rs, input int h, input int v,
                      input int f, input int t, input logic [4:0] flg);
    enable  = en;
    restart = rs;
    exp_q.push_back({12'(h), 12'(v), 8'(f), 2'(t), flg});
    id_q.push_back(vec_n++);
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    obs_t act, e;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        id  = id_q.pop_front();
        act = {h_count, v_count, f_count, cp_ticks,
               {start_sample, sample_adv, eol, eof, cmp_hit}};
        applied++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got h=%0d v=%0d f=%0d t=%0d flags=%b, expected h=%0d v=%0d f=%0d t=%0d flags=%b",
                   id, act.h, act.v, act.f, act.t, act.flg, e.h, e.v, e.f, e.t, e.flg);
        end
      end
    end
  end
  initial begin : driver
    reset_n = 1'b0; enable = 1'b0; restart = 1'b0; ticks_m1 = 2'd0;
    h_max = 12'd3; v_max = 12'd1; h_reload = '0; v_reload = '0;
    h_cmp = 12'hfff; v_cmp = 12'hfff;
    @(posedge clk);
    #1;
    // reset value H_RESET_VALUE=5, during and after reset
    step(0, 0, 5, 0, 0, 0, 5'b10000);
    step(0, 0, 5, 0, 0, 0, 5'b10000);
    reset_n = 1'b1;
    step(0, 0, 5, 0, 0, 0, 5'b10000);
    step(0, 1, 5, 0, 0, 0, 5'b10000);
    // one sample per cycle, 4x2 raster
    step(1, 0, 0, 0, 0, 0, 5'b11000);
    step(1, 0, 1, 0, 0, 0, 5'b11000);
    step(1, 0, 2, 0, 0, 0, 5'b11000);
    step(1, 0, 3, 0, 0, 0, 5'b11100);
    step(1, 0, 0, 1, 0, 0, 5'b11000);
    step(1, 0, 1, 1, 0, 0, 5'b11000);
    step(1, 0, 2, 1, 0, 0, 5'b11000);
    step(1, 0, 3, 1, 0, 0, 5'b11110);
    step(0, 0, 0, 0, 1, 0, 5'b10000);
    // three ticks per sample, h_max=1
    ticks_m1 = 2'd2; h_max = 12'd1;
    step(1, 0, 0, 0, 1, 0, 5'b10000);
    step(1, 0, 0, 0, 1, 1, 5'b00000);
    step(1, 0, 0, 0, 1, 2, 5'b01000);
    step(1, 0, 1, 0, 1, 0, 5'b10000);
    step(1, 0, 1, 0, 1, 1, 5'b00000);
    step(1, 0, 1, 0, 1, 2, 5'b01100);
    step(1, 0, 0, 1, 1, 0, 5'b10000);
    step(1, 0, 0, 1, 1, 1, 5'b00000);
    step(1, 0, 0, 1, 1, 2, 5'b01000);
    step(0, 0, 1, 1, 1, 0, 5'b10000);
    // h_max lowered below the count, then enable toggling
    h_reload = 12'd9; v_reload = 12'd0; ticks_m1 = 2'd0; h_max = 12'd4;
    step(0, 1, 1, 1, 1, 0, 5'b10000);
    step(1, 0, 9, 0, 1, 0, 5'b11100);
    step(0, 0, 0, 1, 1, 0, 5'b10000);
    step(1, 0, 0, 1, 1, 0, 5'b11000);
    step(0, 0, 1, 1, 1, 0, 5'b10000);
    step(0, 0, 1, 1, 1, 0, 5'b10000);
    // prescaler frozen mid-sample while enable is low
    ticks_m1 = 2'd2;
    step(1, 0, 1, 1, 1, 0, 5'b10000);
    step(0, 0, 1, 1, 1, 1, 5'b00000);
    step(0, 0, 1, 1, 1, 1, 5'b00000);
    step(1, 0, 1, 1, 1, 1, 5'b00000);
    step(1, 0, 1, 1, 1, 2, 5'b01000);
    // restart beats enable at end of frame with a nonzero phase
    ticks_m1 = 2'd1; h_max = 12'd3; h_reload = 12'd2; v_reload = 12'd7;
    step(1, 0, 2, 1, 1, 0, 5'b10000);
    step(1, 0, 2, 1, 1, 1, 5'b01000);
    step(1, 0, 3, 1, 1, 0, 5'b10000);
    step(1, 1, 3, 1, 1, 1, 5'b01110);
    step(0, 0, 2, 7, 1, 0, 5'b10000);
    // compare at (2,0), once per frame
    ticks_m1 = 2'd0; h_reload = 12'd0; v_reload = 12'd0; h_cmp = 12'd2; v_cmp = 12'd0;
    step(0, 1, 2, 7, 1, 0, 5'b10000);
    step(1, 0, 0, 0, 1, 0, 5'b11000);
    step(1, 0, 1, 0, 1, 0, 5'b11000);
    step(1, 0, 2, 0, 1, 0, 5'b11001);
    step(1, 0, 3, 0, 1, 0, 5'b11100);
    step(1, 0, 0, 1, 1, 0, 5'b11000);
    step(1, 0, 1, 1, 1, 0, 5'b11000);
    step(1, 0, 2, 1, 1, 0, 5'b11000);
    step(1, 0, 3, 1, 1, 0, 5'b11110);
    step(1, 0, 0, 0, 2, 0, 5'b11000);
    step(1, 0, 1, 0, 2, 0, 5'b11000);
    step(1, 0, 2, 0, 2, 0, 5'b11001);
    step(1, 0, 3, 0, 2, 0, 5'b11100);
    // restart onto the compare position also pulses cmp_hit
    h_reload = 12'd2;
    step(0, 1, 0, 1, 2, 0, 5'b10000);
    step(0, 0, 2, 0, 2, 0, 5'b10001);
    step(0, 0, 2, 0, 2, 0, 5'b10000);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
